// File: rtl/spi_txn_sequencer_pkg.sv
// Shared constants and state type for the SPI transaction sequencer.
// Core register map, status bit positions and control values used by the FSM.
package spi_seq_pkg;

   localparam logic [2:0] SPI_RX      = 3'd0;
   localparam logic [2:0] SPI_TX      = 3'd1;
   localparam logic [2:0] SPI_STATUS  = 3'd2;
   localparam logic [2:0] SPI_CONTROL = 3'd3;
   localparam logic [2:0] SPI_SS      = 3'd5;

   localparam int STAT_RRDY = 7;
   localparam int STAT_TMT  = 5;
   localparam int STAT_ROE  = 3;

   localparam logic [15:0] CTRL_SSO = 16'h0400;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_SSO_ON,
      S_TX,
      S_POLL,
      S_RX,
      S_RD_OUT,
      S_SSO_OFF,
      S_ABORT
   } seq_state_t;

   // MAX3421E-style command byte: register number, direction bit, no ACKSTAT.
   function automatic logic [7:0] hdr_byte(input logic [4:0] reg_num, input logic is_write);
      return {reg_num, 1'b0, is_write, 1'b0};
   endfunction

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Fabric command/stream signals and SPI core register port of the sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
interface spi_seq_if;
   import spi_seq_pkg::*;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_reg;
   logic        cmd_write;
   logic [3:0]  cmd_len;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [7:0]  hdr_status;
   logic        done;
   logic        err;
   logic        spi_select;
   logic        spi_read_n;
   logic        spi_write_n;
   logic [2:0]  spi_addr;
   logic [15:0] spi_wdata;
   logic [15:0] spi_rdata;
   seq_state_t  dbg_state;

   modport slave (
      input  cmd_valid, cmd_reg, cmd_write, cmd_len, wr_data, wr_valid, rd_ready, spi_rdata,
      output cmd_ready, wr_ready, rd_data, rd_valid, hdr_status, done, err,
             spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata, dbg_state
   );

   modport master (
      output cmd_valid, cmd_reg, cmd_write, cmd_len, wr_data, wr_valid, rd_ready, spi_rdata,
      input  cmd_ready, wr_ready, rd_data, rd_valid, hdr_status, done, err,
             spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata, dbg_state
   );

endinterface

// File: rtl/spi_txn_sequencer_reg_access.sv
// Two-cycle register access engine for the SPI master core port.
// Strobes are held for two cycles, then dropped for a gap cycle that carries the ack.
module spi_reg_access (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic [2:0]  i_addr,
   input  logic [15:0] i_wdata,
   input  logic        i_we,
   output logic        o_start,
   output logic        o_ack,
   output logic [15:0] o_rdata,
   output logic        o_select,
   output logic        o_read_n,
   output logic        o_write_n,
   output logic [2:0]  o_addr,
   output logic [15:0] o_wdata,
   input  logic [15:0] i_spi_rdata
);

   typedef enum logic [1:0] {A_IDLE, A_CYC1, A_CYC2, A_GAP} acc_phase_t;

   acc_phase_t  r_phase;
   logic        r_select;
   logic        r_read_n;
   logic        r_write_n;
   logic [2:0]  r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic        w_start;

   assign w_start   = (r_phase == A_IDLE) && i_req;
   assign o_start   = w_start;
   assign o_ack     = (r_phase == A_GAP);
   assign o_rdata   = r_rdata;
   assign o_select  = r_select;
   assign o_read_n  = r_read_n;
   assign o_write_n = r_write_n;
   assign o_addr    = r_addr;
   assign o_wdata   = r_wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase   <= A_IDLE;
         r_select  <= 1'b0;
         r_read_n  <= 1'b1;
         r_write_n <= 1'b1;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
      end else begin
         case (r_phase)
            A_IDLE: begin
               if (w_start) begin
                  r_phase   <= A_CYC1;
                  r_select  <= 1'b1;
                  r_read_n  <= i_we;
                  r_write_n <= !i_we;
                  r_addr    <= i_addr;
                  r_wdata   <= i_wdata;
               end
            end
            A_CYC1: r_phase <= A_CYC2;
            A_CYC2: begin
               // Read data is taken on the edge that ends the second strobe cycle.
               r_phase   <= A_GAP;
               r_select  <= 1'b0;
               r_read_n  <= 1'b1;
               r_write_n <= 1'b1;
               r_rdata   <= i_spi_rdata;
            end
            default: r_phase <= A_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Runs chip-select-framed MAX3421E-style transactions (header + 1..MAX_LEN bytes)
// through the SPI master core's register port.
module spi_txn_sequencer
   import spi_seq_pkg::*;
#(
   parameter int MAX_LEN    = 8,
   parameter int POLL_LIMIT = 255
) (
   input logic       clk,
   input logic       reset_n,
   spi_seq_if.slave  bus
);

   localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);
   localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

   seq_state_t  r_state;
   seq_state_t  w_next;
   logic [4:0]  r_reg;
   logic        r_write;
   logic [3:0]  r_left;
   logic        r_first;
   logic [7:0]  r_poll_cnt;
   logic [7:0]  r_hdr_status;
   logic [7:0]  r_rd_data;

   logic        w_req;
   logic [2:0]  w_addr;
   logic [15:0] w_wdata;
   logic        w_we;
   logic        w_start;
   logic        w_ack;
   logic [15:0] w_rdata;
   logic        w_wr_ready;
   logic        w_done;
   logic        w_err;
   logic [3:0]  w_len;
   logic        w_unused_rdata_hi;

   assign w_unused_rdata_hi = ^w_rdata[15:8];

   assign w_len = (bus.cmd_len == 4'd0)     ? 4'd1 :
                  (bus.cmd_len > MAX_LEN_L) ? MAX_LEN_L : bus.cmd_len;

   spi_reg_access u_acc (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req       (w_req),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .i_we        (w_we),
      .o_start     (w_start),
      .o_ack       (w_ack),
      .o_rdata     (w_rdata),
      .o_select    (bus.spi_select),
      .o_read_n    (bus.spi_read_n),
      .o_write_n   (bus.spi_write_n),
      .o_addr      (bus.spi_addr),
      .o_wdata     (bus.spi_wdata),
      .i_spi_rdata (bus.spi_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_req      = 1'b0;
      w_addr     = SPI_RX;
      w_wdata    = '0;
      w_we       = 1'b0;
      w_wr_ready = 1'b0;
      w_done     = 1'b0;
      w_err      = 1'b0;
      case (r_state)
         S_IDLE: if (bus.cmd_valid) w_next = S_CLR;
         S_CLR: begin
            w_req  = 1'b1;
            w_addr = SPI_STATUS;
            w_we   = 1'b1;
            if (w_ack) w_next = S_SSO_ON;
         end
         S_SSO_ON: begin
            w_req   = 1'b1;
            w_addr  = SPI_CONTROL;
            w_wdata = CTRL_SSO;
            w_we    = 1'b1;
            if (w_ack) w_next = S_TX;
         end
         S_TX: begin
            w_addr = SPI_TX;
            w_we   = 1'b1;
            if (r_first) begin
               w_wdata = {8'h00, hdr_byte(r_reg, r_write)};
               w_req   = 1'b1;
            end else if (r_write) begin
               // The stream byte is consumed in the cycle the core write is launched.
               w_wdata    = {8'h00, bus.wr_data};
               w_req      = bus.wr_valid;
               w_wr_ready = w_start;
            end else begin
               w_req = 1'b1;
            end
            if (w_ack) w_next = S_POLL;
         end
         S_POLL: begin
            w_req  = 1'b1;
            w_addr = SPI_STATUS;
            if (w_ack) begin
               if (w_rdata[STAT_ROE])             w_next = S_ABORT;
               else if (w_rdata[STAT_RRDY])       w_next = S_RX;
               else if (r_poll_cnt == POLL_LAST)  w_next = S_ABORT;
            end
         end
         S_RX: begin
            w_req  = 1'b1;
            w_addr = SPI_RX;
            if (w_ack) begin
               if (r_first)             w_next = S_TX;
               else if (!r_write)       w_next = S_RD_OUT;
               else if (r_left == 4'd1) w_next = S_SSO_OFF;
               else                     w_next = S_TX;
            end
         end
         S_RD_OUT: begin
            if (bus.rd_ready) w_next = (r_left == 4'd0) ? S_SSO_OFF : S_TX;
         end
         S_SSO_OFF: begin
            w_req  = 1'b1;
            w_addr = SPI_CONTROL;
            w_we   = 1'b1;
            if (w_ack) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_ABORT: begin
            w_req  = 1'b1;
            w_addr = SPI_CONTROL;
            w_we   = 1'b1;
            if (w_ack) begin
               w_done = 1'b1;
               w_err  = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reg        <= '0;
         r_write      <= 1'b0;
         r_left       <= '0;
         r_first      <= 1'b0;
         r_poll_cnt   <= '0;
         r_hdr_status <= '0;
         r_rd_data    <= '0;
      end else begin
         if (r_state == S_IDLE && bus.cmd_valid) begin
            r_reg   <= bus.cmd_reg;
            r_write <= bus.cmd_write;
            r_left  <= w_len;
            r_first <= 1'b1;
         end
         if (r_state == S_TX) r_poll_cnt <= '0;
         if (r_state == S_POLL && w_ack) r_poll_cnt <= r_poll_cnt + 8'd1;
         if (r_state == S_RX && w_ack) begin
            if (r_first) begin
               r_hdr_status <= w_rdata[7:0];
               r_first      <= 1'b0;
            end else begin
               r_left <= r_left - 4'd1;
               if (!r_write) r_rd_data <= w_rdata[7:0];
            end
         end
      end
   end

   assign bus.cmd_ready  = (r_state == S_IDLE);
   assign bus.wr_ready   = w_wr_ready;
   assign bus.rd_valid   = (r_state == S_RD_OUT);
   assign bus.rd_data    = r_rd_data;
   assign bus.hdr_status = r_hdr_status;
   assign bus.done       = w_done;
   assign bus.err        = w_err;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI core register model.
// Checks tx bytes against an expected queue plus control writes, polls and stream handshakes.
module tb_spi_txn_sequencer;
   import spi_seq_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   spi_seq_if bus ();

   spi_txn_sequencer #(.MAX_LEN(8), .POLL_LIMIT(255)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Core model: status register value and a table of rx bytes served in order.
   logic [7:0] status_val;
   logic [7:0] rx_bytes [0:15];
   int         rx_idx;
   assign bus.spi_rdata = (bus.spi_addr == SPI_STATUS) ? {8'h00, status_val}
                                                       : {8'h00, rx_bytes[rx_idx[3:0]]};

   logic [7:0]  exp_q[$];
   int          sel_len, acc_cnt, proto_err, stat_reads, wr_pulses;
   int          done_cnt, err_cnt, done_err_cnt, accepts, busy_ready, ctrl_n, rd_n;
   logic [31:0] ctrl_sig, rd_sig;
   logic [2:0]  a_addr, first_addr;
   logic [15:0] a_wdata;
   logic        a_rn, a_wn;

   always @(negedge clk) begin
      if (!reset_n) begin
         sel_len = 0;
      end else begin
         if (bus.spi_select) begin
            sel_len++;
            if (sel_len == 1) begin
               a_addr  = bus.spi_addr;
               a_wdata = bus.spi_wdata;
               a_rn    = bus.spi_read_n;
               a_wn    = bus.spi_write_n;
               acc_cnt++;
               if (acc_cnt == 1) first_addr = a_addr;
               if (!a_wn && a_addr == SPI_TX) begin
                  if (exp_q.size() == 0) check_eq("tx_extra", 64'(exp_q.size()), 64'd1);
                  else check_eq("tx_byte", 64'(a_wdata), 64'(exp_q.pop_front()));
               end
               if (!a_wn && a_addr == SPI_CONTROL) begin
                  ctrl_sig = {ctrl_sig[15:0], a_wdata};
                  ctrl_n++;
               end
               if (!a_rn && a_addr == SPI_STATUS) stat_reads++;
            end else if (bus.spi_addr != a_addr || bus.spi_wdata != a_wdata ||
                         bus.spi_read_n != a_rn || bus.spi_write_n != a_wn) begin
               proto_err++;
            end
         end else if (sel_len != 0) begin
            if (sel_len != 2) proto_err++;
            if (a_addr == SPI_RX && !a_rn) rx_idx++;
            sel_len = 0;
         end
         if (bus.wr_ready) wr_pulses++;
         if (bus.rd_valid && bus.rd_ready) begin
            rd_sig = {rd_sig[23:0], bus.rd_data};
            rd_n++;
         end
         if (bus.done) done_cnt++;
         if (bus.err) err_cnt++;
         if (bus.done && bus.err) done_err_cnt++;
         if (bus.cmd_valid && bus.cmd_ready) accepts++;
         if (bus.dbg_state != S_IDLE && bus.cmd_ready) busy_ready++;
      end
   end

   task automatic clear_logs();
      exp_q.delete();
      rx_idx = 0; acc_cnt = 0; proto_err = 0; stat_reads = 0; wr_pulses = 0;
      done_cnt = 0; err_cnt = 0; done_err_cnt = 0; accepts = 0; busy_ready = 0;
      ctrl_n = 0; rd_n = 0; ctrl_sig = '0; rd_sig = '0; first_addr = '0;
   endtask

   function automatic logic [42:0] out_vec();
      return {bus.cmd_ready, bus.spi_select, bus.spi_read_n, bus.spi_write_n, bus.spi_addr,
              bus.spi_wdata, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.hdr_status,
              bus.done, bus.err};
   endfunction

   localparam logic [42:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0,
                                        8'd0, 8'd0, 1'b0, 1'b0};

   task automatic start_cmd(input logic [4:0] r, input logic w, input logic [3:0] len);
      logic ok;
      ok = 1'b0;
      bus.cmd_reg = r; bus.cmd_write = w; bus.cmd_len = len; bus.cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check_eq("cmd_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin seen = 1'b1; break; end
      end
      check_eq("done_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_wr(input logic [7:0] d);
      logic ok;
      ok = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.wr_data = d; bus.wr_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.wr_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
      check_eq("wr_accept", 64'(ok), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] held;
      int         acc0, stall_bad;
      logic       ok;

      bus.cmd_valid = 1'b0; bus.cmd_reg = '0; bus.cmd_write = 1'b0; bus.cmd_len = '0;
      bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
      status_val = 8'h80;
      for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
      clear_logs();

      // reset values
      #12;
      check_eq("reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
      check_eq("reset_state", 64'(bus.dbg_state), 64'(S_IDLE));
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // read reg 18, len 1
      clear_logs();
      rx_bytes[0] = 8'h5A; rx_bytes[1] = 8'hC3;
      exp_q.push_back(8'h90); exp_q.push_back(8'h00);
      start_cmd(5'd18, 1'b0, 4'd1);
      wait_done(500);
      check_eq("t1_hdr_status", 64'(bus.hdr_status), 64'h5A);
      check_eq("t1_rd_count", 64'(rd_n), 64'd1);
      check_eq("t1_rd_data", 64'(rd_sig), 64'hC3);
      check_eq("t1_ctrl", {32'(ctrl_n), ctrl_sig}, {32'd2, 32'h0400_0000});
      check_eq("t1_done_err", {32'(done_cnt), 32'(err_cnt)}, {32'd1, 32'd0});
      check_eq("t1_tx_left", 64'(exp_q.size()), 64'd0);
      check_eq("t1_proto", 64'(proto_err), 64'd0);

      // write reg 17, len 3, gapped stream
      clear_logs();
      rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33; rx_bytes[3] = 8'h44;
      exp_q.push_back(8'h8A); exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      start_cmd(5'd17, 1'b1, 4'd3);
      fork
         begin send_wr(8'h01); send_wr(8'h02); send_wr(8'h03); end
         wait_done(1500);
      join
      check_eq("t2_wr_pulses", 64'(wr_pulses), 64'd3);
      check_eq("t2_no_rd", 64'(rd_n), 64'd0);
      check_eq("t2_hdr_status", 64'(bus.hdr_status), 64'h11);
      check_eq("t2_tx_left", 64'(exp_q.size()), 64'd0);
      check_eq("t2_proto", 64'(proto_err), 64'd0);

      // read reg 3, len 2, consumer stalls 40 cycles
      clear_logs();
      bus.rd_ready = 1'b0;
      rx_bytes[0] = 8'h01; rx_bytes[1] = 8'hA1; rx_bytes[2] = 8'hB2;
      exp_q.push_back(8'h18); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      start_cmd(5'd3, 1'b0, 4'd2);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.rd_valid) begin ok = 1'b1; break; end
      end
      check_eq("t3_rd_valid_seen", 64'(ok), 64'd1);
      held = bus.rd_data;
      acc0 = acc_cnt;
      stall_bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (!bus.rd_valid || bus.rd_data != held) stall_bad++;
      end
      check_eq("t3_stall_hold", 64'(stall_bad), 64'd0);
      check_eq("t3_held_data", 64'(held), 64'hA1);
      check_eq("t3_no_access", 64'(acc_cnt), 64'(acc0));
      @(posedge clk); #1 bus.rd_ready = 1'b1;
      wait_done(500);
      check_eq("t3_rd_stream", {32'(rd_n), rd_sig}, {32'd2, 32'h0000_A1B2});
      check_eq("t3_tx_left", 64'(exp_q.size()), 64'd0);

      // RRDY never set: poll timeout
      clear_logs();
      status_val = 8'h00;
      exp_q.push_back(8'h08);
      start_cmd(5'd1, 1'b0, 4'd1);
      wait_done(3000);
      check_eq("t4_status_reads", 64'(stat_reads), 64'd255);
      check_eq("t4_ctrl", {32'(ctrl_n), ctrl_sig}, {32'd2, 32'h0400_0000});
      check_eq("t4_done_with_err", {32'(done_err_cnt), 32'(err_cnt)}, {32'd1, 32'd1});
      check_eq("t4_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check_eq("t4_tx_left", 64'(exp_q.size()), 64'd0);

      // ROE on first poll aborts at once
      clear_logs();
      status_val = 8'h08;
      exp_q.push_back(8'h48);
      start_cmd(5'd9, 1'b0, 4'd1);
      wait_done(500);
      check_eq("t4b_status_reads", 64'(stat_reads), 64'd1);
      check_eq("t4b_done_with_err", 64'(done_err_cnt), 64'd1);

      // reset in the middle of POLL
      clear_logs();
      status_val = 8'h00;
      exp_q.push_back(8'h10);
      start_cmd(5'd2, 1'b0, 4'd1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.dbg_state == S_POLL) begin ok = 1'b1; break; end
      end
      check_eq("t5_reached_poll", 64'(ok), 64'd1);
      repeat (6) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("t5_async_reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
      check_eq("t5_async_reset_state", 64'(bus.dbg_state), 64'(S_IDLE));
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      clear_logs();
      status_val = 8'h80;
      rx_bytes[0] = 8'h5A; rx_bytes[1] = 8'hC3;
      exp_q.push_back(8'h90); exp_q.push_back(8'h00);
      start_cmd(5'd18, 1'b0, 4'd1);
      wait_done(500);
      check_eq("t5_first_access_clr", 64'(first_addr), 64'(SPI_STATUS));
      check_eq("t5_ctrl", {32'(ctrl_n), ctrl_sig}, {32'd2, 32'h0400_0000});
      check_eq("t5_rd_data", {32'(rd_n), rd_sig}, {32'd1, 32'h0000_00C3});
      check_eq("t5_hdr_status", 64'(bus.hdr_status), 64'h5A);
      check_eq("t5_proto", 64'(proto_err), 64'd0);

      // cmd_valid held across a busy transaction
      clear_logs();
      rx_bytes[0] = 8'h31; rx_bytes[1] = 8'hD1; rx_bytes[2] = 8'h32; rx_bytes[3] = 8'hD2;
      exp_q.push_back(8'h10); exp_q.push_back(8'h00); exp_q.push_back(8'h20); exp_q.push_back(8'h00);
      bus.cmd_reg = 5'd2; bus.cmd_write = 1'b0; bus.cmd_len = 4'd1; bus.cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.dbg_state != S_IDLE) begin ok = 1'b1; break; end
      end
      check_eq("t6_first_accept", 64'(ok), 64'd1);
      check_eq("t6_busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      bus.cmd_reg = 5'd4;
      wait_done(500);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.dbg_state != S_IDLE) begin ok = 1'b1; break; end
      end
      check_eq("t6_second_accept", 64'(ok), 64'd1);
      @(posedge clk); #1 bus.cmd_valid = 1'b0;
      wait_done(500);
      check_eq("t6_accepts", 64'(accepts), 64'd2);
      check_eq("t6_busy_ready", 64'(busy_ready), 64'd0);
      check_eq("t6_rd_stream", {32'(rd_n), rd_sig}, {32'd2, 32'h0000_D1D2});
      check_eq("t6_done_cnt", 64'(done_cnt), 64'd2);
      check_eq("t6_tx_left", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Hardware command engine that drives the SPI master core's 3-bit-address register port, so software does not have to bit-poll it.
- Runs complete chip-select-framed transactions for a MAX3421E-style peripheral: header byte, then 1..MAX_LEN data bytes.
- Sits directly upstream of the SPI master. A command/stream interface faces the fabric; a simple register-master port faces the SPI core.

Parameters:
- MAX_LEN, 8, maximum data bytes per transaction. cmd_len is 1..MAX_LEN.
- POLL_LIMIT, 255, maximum status reads while waiting for RRDY before the transaction aborts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_reg  in  5  peripheral register number
- cmd_write  in  1  1 = write transaction, 0 = read transaction
- cmd_len  in  4  number of data bytes, 1..MAX_LEN
- wr_data  in  8  write byte stream
- wr_valid  in  1  write byte offered
- wr_ready  out  1  write byte accepted this cycle
- rd_data  out  8  read byte stream
- rd_valid  out  1  read byte available
- rd_ready  in  1  consumer accepts read byte
- hdr_status  out  8  byte received during the header
- done  out  1  one-cycle pulse at end of transaction
- err  out  1  one-cycle pulse with done on poll timeout or ROE
- spi_select  out  1  core access strobe
- spi_read_n  out  1  core read, active low
- spi_write_n  out  1  core write, active low
- spi_addr  out  3  core register address
- spi_wdata  out  16  core write data
- spi_rdata  in  16  core read data

Behaviour:
- Reset values:
  - cmd_ready=1, spi_select=0, spi_read_n=1, spi_write_n=1, spi_addr=0, spi_wdata=0.
  - wr_ready=0, rd_valid=0, rd_data=0, hdr_status=0, done=0, err=0.
- Reset mid-transaction returns to IDLE immediately. The SPI core shares reset_n, so SSO clears with it.
- Core access:
  - Every access is exactly 2 cycles, with spi_select, addr, data and rd/wr held stable for both.
  - Read data is sampled at the end of the second cycle.
  - Strobes are deasserted for at least 1 idle cycle between accesses.
- Core register map used:
  - 0 rx; 1 tx; 2 status (RRDY bit7, TMT bit5, ROE bit3); 3 control (SSO bit10); 5 slave-select.
- Command capture:
  - On cmd_valid & cmd_ready, latch reg/write/len. cmd_len = 0 is treated as 1; values above MAX_LEN are clamped.
  - Header byte = {cmd_reg, 1'b0, cmd_write, 1'b0}.
- FSM states:
  - IDLE: on command, go to CLR.
  - CLR: write status (any data) to clear stale flags, then go to SSO_ON.
  - SSO_ON: write control = 0x0400, then go to TX.
  - TX: write tx with the header (first pass), wr_data (write transaction), or 0x00 (read transaction), then go to POLL.
    - Write transaction: stall in TX with wr_ready low until wr_valid. wr_ready pulses for 1 cycle, in the cycle the core write begins.
  - POLL: read status. If RRDY=1, go to RX. If not, increment the poll counter; on reaching POLL_LIMIT, go to ABORT.
  - RX: read rx.
    - First byte goes to hdr_status.
    - Later bytes on a read transaction go to RD_OUT.
    - Later bytes on a write transaction are discarded.
    - Then go to TX while bytes remain, else to SSO_OFF.
  - RD_OUT: hold rd_valid/rd_data until rd_ready, then go to TX or SSO_OFF. The SPI clock is idle while stalled.
  - SSO_OFF: write control = 0x0000, pulse done, go to IDLE.
  - ABORT: write control = 0x0000, pulse done and err, go to IDLE.
- ROE=1 seen in any POLL forces ABORT.
- Byte counter is 4 bits and counts down from len. There is no wrap-around.
- The poll counter is 8 bits and resets on each new TX.

Decomposition:
- Shared package spi_seq_pkg holds:
  - Core address constants (SPI_RX=0, SPI_TX=1, SPI_STATUS=2, SPI_CONTROL=3, SPI_SS=5).
  - Status bit indices and the CTRL_SSO mask.
  - The FSM state enum.
- One natural sub-module: spi_reg_access. It takes req/addr/wdata/we and returns ack/rdata, and owns the 2-cycle access timing plus the idle gap.

Test Plan:
- Read transaction, reg=18, len=1; core model returns 0x5A then 0xC3 -> header 0x90 on tx, hdr_status=0x5A, rd_data=0xC3 once, done pulse, control writes 0x0400 then 0x0000.
- Write transaction, reg=17, len=3, wr_data 0x01/0x02/0x03 with wr_valid gaps of 5 cycles -> tx sequence 0x8A,0x01,0x02,0x03; exactly 3 wr_ready pulses; no rd_valid.
- Read with len=2 and rd_ready held low 40 cycles -> rd_valid stays high with stable rd_data; no further core access until acceptance.
- RRDY never set -> exactly 255 status reads, then control=0x0000, done&err pulse together, cmd_ready=1.
- reset_n low mid-POLL -> all outputs at reset values asynchronously; next command runs normally from CLR.
- cmd_valid held during a busy transaction -> cmd_ready=0 and the second command is accepted only after done.
